// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions used by the hazard controller: jump/branch codes,
// FSM state encoding and the ID-stage register dependency helper.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        JB_OTHERS = 3'd0,
        JB_BEQ    = 3'd1,
        JB_BNE    = 3'd2,
        JB_JR     = 3'd3,
        JB_J      = 3'd4,
        JB_JAL    = 3'd7
    } jb_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // True when a producer writing wr_addr feeds an operand the ID instruction reads.
    function automatic logic id_dep(
        input logic              reg_write,
        input logic [REG_AW-1:0] wr_addr,
        input logic              use_rs,
        input logic [REG_AW-1:0] rs_addr,
        input logic              use_rt,
        input logic [REG_AW-1:0] rt_addr
    );
        return reg_write && (wr_addr != '0) &&
               ((use_rs && (wr_addr == rs_addr)) || (use_rt && (wr_addr == rt_addr)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID/EX/MEM status in, stall/flush controls out.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [2:0]        ID_JumpBranch;
    logic [REG_AW-1:0] ID_rsAddr;
    logic [REG_AW-1:0] ID_rtAddr;
    logic              ID_UseRs;
    logic              ID_UseRt;
    logic              ID_MemWrite;
    logic              ID_Taken;
    logic [REG_AW-1:0] EX_wrAddr;
    logic              EX_RegWrite;
    logic              EX_MemtoReg;
    logic [REG_AW-1:0] MEM_wrAddr;
    logic              MEM_RegWrite;
    logic              MEM_MemtoReg;
    logic              Mem_Busy;

    logic              PC_Write;
    logic              IFID_Write;
    logic              IFID_Flush;
    logic              IDEX_Flush;
    logic              Pipe_Freeze;
    logic [CNT_W-1:0]  Stall_Count;
    logic [CNT_W-1:0]  Flush_Count;

    modport master (
        output ID_JumpBranch, ID_rsAddr, ID_rtAddr, ID_UseRs, ID_UseRt, ID_MemWrite, ID_Taken,
        output EX_wrAddr, EX_RegWrite, EX_MemtoReg, MEM_wrAddr, MEM_RegWrite, MEM_MemtoReg,
        output Mem_Busy,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, Stall_Count, Flush_Count
    );

    modport slave (
        input  ID_JumpBranch, ID_rsAddr, ID_rtAddr, ID_UseRs, ID_UseRt, ID_MemWrite, ID_Taken,
        input  EX_wrAddr, EX_RegWrite, EX_MemtoReg, MEM_wrAddr, MEM_RegWrite, MEM_MemtoReg,
        input  Mem_Busy,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, Stall_Count, Flush_Count
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter32.sv
// Event counter that sticks at all-ones instead of wrapping; width defaults to 32.
module sat_counter32 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard controller: multi-cycle stall FSM, taken-branch
// flush, memory-busy freeze and saturating stall/flush event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave hz
);

    state_e     state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic [1:0] need;
    logic [1:0] need_m1;
    logic       branch_jr;
    logic       dep_ex;
    logic       dep_mem;
    logic       load_use;
    logic       stall;
    logic       stall_cyc;
    logic       flush_cyc;

    always_comb begin
        branch_jr = (hz.ID_JumpBranch == JB_BEQ) || (hz.ID_JumpBranch == JB_BNE) ||
                    (hz.ID_JumpBranch == JB_JR);
        dep_ex    = id_dep(hz.EX_RegWrite, hz.EX_wrAddr, hz.ID_UseRs, hz.ID_rsAddr,
                           hz.ID_UseRt, hz.ID_rtAddr);
        dep_mem   = id_dep(hz.MEM_RegWrite, hz.MEM_wrAddr, hz.ID_UseRs, hz.ID_rsAddr,
                           hz.ID_UseRt, hz.ID_rtAddr);
        // A store's rt is picked up later by WB->MEM forwarding, so it never waits on a load.
        load_use  = !branch_jr && hz.EX_MemtoReg && id_dep(hz.EX_RegWrite, hz.EX_wrAddr,
                    hz.ID_UseRs, hz.ID_rsAddr, hz.ID_UseRt && !hz.ID_MemWrite, hz.ID_rtAddr);

        need = 2'd0;
        if (branch_jr && dep_ex && hz.EX_MemtoReg) begin
            need = 2'd2;
        end else if ((branch_jr && dep_ex) || (branch_jr && dep_mem && hz.MEM_MemtoReg) ||
                     load_use) begin
            need = 2'd1;
        end
        need_m1 = need - 2'd1;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall   = 1'b0;
        if (!hz.Mem_Busy) begin
            unique case (state_q)
                ST_RUN: begin
                    if (need != 2'd0) begin
                        stall   = 1'b1;
                        rem_d   = need_m1;
                        state_d = (need_m1 != 2'd0) ? ST_HOLD : ST_RUN;
                    end
                end
                ST_HOLD: begin
                    stall   = 1'b1;
                    rem_d   = (rem_q != 2'd0) ? rem_q - 2'd1 : 2'd0;
                    state_d = (rem_q <= 2'd1) ? ST_RUN : ST_HOLD;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        hz.PC_Write    = 1'b1;
        hz.IFID_Write  = 1'b1;
        hz.IFID_Flush  = 1'b0;
        hz.IDEX_Flush  = 1'b0;
        hz.Pipe_Freeze = 1'b0;
        if (rst) begin
            hz.PC_Write   = 1'b0;
            hz.IFID_Write = 1'b0;
            hz.IFID_Flush = 1'b1;
            hz.IDEX_Flush = 1'b1;
        end else if (hz.Mem_Busy) begin
            hz.PC_Write    = 1'b0;
            hz.IFID_Write  = 1'b0;
            hz.Pipe_Freeze = 1'b1;
        end else if (stall) begin
            hz.PC_Write   = 1'b0;
            hz.IFID_Write = 1'b0;
            hz.IDEX_Flush = 1'b1;
        end else if (hz.ID_Taken) begin
            hz.IFID_Flush = 1'b1;
        end
    end

    assign stall_cyc = stall && !rst;
    assign flush_cyc = hz.IFID_Flush && !rst;

    // NOTE: only control state is reset; there is no storage array here to clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    sat_counter32 #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_cyc),
        .q   (hz.Stall_Count)
    );

    sat_counter32 #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_cyc),
        .q   (hz.Flush_Count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus stall/busy/reset/flush
// sequences and a narrow saturating-counter instance to exercise the clamp.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    logic       sc_rst = 1'b1;
    logic       sc_inc = 1'b0;
    logic [2:0] sc_q;

    sat_counter32 #(.W(3)) u_sc (
        .clk (clk),
        .rst (sc_rst),
        .inc (sc_inc),
        .q   (sc_q)
    );

    typedef struct {
        logic [2:0] jb;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       mw;
        logic       taken;
        logic [4:0] ex_wr;
        logic       ex_rw;
        logic       ex_m2r;
        logic [4:0] mem_wr;
        logic       mem_rw;
        logic       mem_m2r;
        logic       busy;
        logic [4:0] exp_ctl;   // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze}
        string      name;
    } vec_t;

    localparam logic [4:0] C_IDLE  = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11100;
    localparam logic [4:0] C_BUSY  = 5'b00001;
    localparam logic [4:0] C_RST   = 5'b00110;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {27'd0, hz.PC_Write, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Flush, hz.Pipe_Freeze};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        hz.ID_JumpBranch = JB_OTHERS;
        hz.ID_rsAddr     = '0;
        hz.ID_rtAddr     = '0;
        hz.ID_UseRs      = 1'b0;
        hz.ID_UseRt      = 1'b0;
        hz.ID_MemWrite   = 1'b0;
        hz.ID_Taken      = 1'b0;
        hz.EX_wrAddr     = '0;
        hz.EX_RegWrite   = 1'b0;
        hz.EX_MemtoReg   = 1'b0;
        hz.MEM_wrAddr    = '0;
        hz.MEM_RegWrite  = 1'b0;
        hz.MEM_MemtoReg  = 1'b0;
        hz.Mem_Busy      = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        hz.ID_JumpBranch = v.jb;
        hz.ID_rsAddr     = v.rs;
        hz.ID_rtAddr     = v.rt;
        hz.ID_UseRs      = v.use_rs;
        hz.ID_UseRt      = v.use_rt;
        hz.ID_MemWrite   = v.mw;
        hz.ID_Taken      = v.taken;
        hz.EX_wrAddr     = v.ex_wr;
        hz.EX_RegWrite   = v.ex_rw;
        hz.EX_MemtoReg   = v.ex_m2r;
        hz.MEM_wrAddr    = v.mem_wr;
        hz.MEM_RegWrite  = v.mem_rw;
        hz.MEM_MemtoReg  = v.mem_m2r;
        hz.Mem_Busy      = v.busy;
    endtask

    // EX holds lw $8, ID holds beq $8,$9: the two-cycle branch stall.
    task automatic set_lw_beq();
        clear_in();
        hz.ID_JumpBranch = JB_BEQ;
        hz.ID_rsAddr     = 5'd8;
        hz.ID_rtAddr     = 5'd9;
        hz.ID_UseRs      = 1'b1;
        hz.ID_UseRt      = 1'b1;
        hz.EX_wrAddr     = 5'd8;
        hz.EX_RegWrite   = 1'b1;
        hz.EX_MemtoReg   = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int exp_stall;
        int exp_flush;

        //          jb  rs  rt  urs urt mw  tk  exwr  rw  m2r mwr  mrw mm2r bsy exp      name
        vecs[0]  = '{3'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_IDLE,  "idle"};
        vecs[1]  = '{3'd3, 5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 1, 0, 5'd0, 0, 0, 0, C_STALL, "jr_ex_alu"};
        vecs[2]  = '{3'd1, 5'd8, 5'd9, 1, 1, 0, 0, 5'd0, 0, 0, 5'd8, 1, 0, 0, C_IDLE,  "beq_mem_alu_fwd"};
        vecs[3]  = '{3'd0, 5'd9, 5'd8, 1, 1, 1, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0, C_IDLE,  "sw_rt_after_lw"};
        vecs[4]  = '{3'd0, 5'd8, 5'd1, 1, 1, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0, C_STALL, "add_load_use"};
        vecs[5]  = '{3'd0, 5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd0, 0, 0, 0, C_IDLE,  "lw_r0"};
        vecs[6]  = '{3'd4, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_FLUSH, "j_taken"};
        vecs[7]  = '{3'd1, 5'd8, 5'd9, 1, 1, 0, 1, 5'd0, 0, 0, 5'd8, 1, 1, 0, C_STALL, "beq_mem_lw_taken"};
        vecs[8]  = '{3'd0, 5'd8, 5'd1, 1, 1, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0, 1, C_BUSY,  "busy_over_stall"};
        vecs[9]  = '{3'd0, 5'd8, 5'd1, 1, 1, 0, 0, 5'd8, 1, 0, 5'd0, 0, 0, 0, C_IDLE,  "add_ex_alu_fwd"};
        vecs[10] = '{3'd3, 5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 0, 0, 5'd0, 0, 0, 0, C_IDLE,  "jr_ex_no_regwrite"};
        vecs[11] = '{3'd2, 5'd3, 5'd8, 1, 1, 0, 0, 5'd8, 1, 0, 5'd0, 0, 0, 0, C_STALL, "bne_rt_ex_alu"};
        vecs[12] = '{3'd0, 5'd8, 5'd9, 1, 1, 1, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0, C_STALL, "sw_rs_after_lw"};
        vecs[13] = '{3'd1, 5'd1, 5'd2, 1, 1, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_FLUSH, "beq_taken_nohaz"};
        vecs[14] = '{3'd4, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, C_BUSY,  "busy_over_flush"};

        // Reset state.
        clear_in();
        step();
        #1;
        check("rst_ctl", ctl(), {27'd0, C_RST});
        do_reset();
        check("rst_stall_cnt", hz.Stall_Count, 32'd0);
        check("rst_flush_cnt", hz.Flush_Count, 32'd0);

        // Single-cycle vectors from RUN; none needs more than one stall cycle.
        exp_stall = 0;
        exp_flush = 0;
        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            check(vecs[i].name, ctl(), {27'd0, vecs[i].exp_ctl});
            if (vecs[i].exp_ctl[1]) exp_stall++;
            if (vecs[i].exp_ctl[2]) exp_flush++;
            step();
        end
        clear_in();
        #1;
        check("table_stall_cnt", hz.Stall_Count, exp_stall);
        check("table_flush_cnt", hz.Flush_Count, exp_flush);

        // lw -> beq: two stall cycles; the second ignores the (now idle) inputs.
        do_reset();
        set_lw_beq();
        #1;
        check("lwbeq_c1", ctl(), {27'd0, C_STALL});
        step();
        check("lwbeq_cnt1", hz.Stall_Count, 32'd1);
        clear_in();
        #1;
        check("lwbeq_c2_hold", ctl(), {27'd0, C_STALL});
        step();
        #1;
        check("lwbeq_c3_run", ctl(), {27'd0, C_IDLE});
        check("lwbeq_cnt2", hz.Stall_Count, 32'd2);

        // HOLD frozen by Mem_Busy for 3 cycles, then the remaining stall cycle.
        do_reset();
        set_lw_beq();
        #1;
        check("busyhold_c1", ctl(), {27'd0, C_STALL});
        step();
        clear_in();
        hz.Mem_Busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("busyhold_frz%0d", k), ctl(), {27'd0, C_BUSY});
            step();
        end
        check("busyhold_cnt_frozen", hz.Stall_Count, 32'd1);
        hz.Mem_Busy = 1'b0;
        #1;
        check("busyhold_resume", ctl(), {27'd0, C_STALL});
        step();
        #1;
        check("busyhold_done", ctl(), {27'd0, C_IDLE});
        check("busyhold_cnt", hz.Stall_Count, 32'd2);

        // Reset asserted mid-HOLD aborts the stall and clears counters.
        do_reset();
        set_lw_beq();
        step();
        clear_in();
        rst = 1'b1;
        #1;
        check("rsthold_ctl", ctl(), {27'd0, C_RST});
        step();
        rst = 1'b0;
        #1;
        check("rsthold_run", ctl(), {27'd0, C_IDLE});
        check("rsthold_stall_cnt", hz.Stall_Count, 32'd0);
        check("rsthold_flush_cnt", hz.Flush_Count, 32'd0);

        // Taken branch while idle flushes IF/ID once.
        hz.ID_Taken = 1'b1;
        #1;
        check("taken_ctl", ctl(), {27'd0, C_FLUSH});
        step();
        clear_in();
        #1;
        check("taken_flush_cnt", hz.Flush_Count, 32'd1);
        check("taken_stall_cnt", hz.Stall_Count, 32'd0);

        // Saturation on a narrow instance of the same counter.
        sc_rst = 1'b1;
        step();
        sc_rst = 1'b0;
        sc_inc = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("sat_count3", {29'd0, sc_q}, 32'd3);
        for (int k = 0; k < 6; k++) step();
        check("sat_clamp", {29'd0, sc_q}, 32'd7);
        sc_inc = 1'b0;
        step();
        check("sat_hold", {29'd0, sc_q}, 32'd7);
        sc_rst = 1'b1;
        step();
        check("sat_rst", {29'd0, sc_q}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ID_JumpBranch in 3 (ID jump/branch code), ID_rsAddr in 5, ID_rtAddr in 5, ID_UseRs in 1, ID_UseRt in 1, ID_MemWrite in 1 (ID is sw), ID_Taken in 1 (ID branch/jump resolved taken).
REQ-003 SHALL have EX_wrAddr in 5, EX_RegWrite in 1, EX_MemtoReg in 1, MEM_wrAddr in 5, MEM_RegWrite in 1, MEM_MemtoReg in 1, Mem_Busy in 1 (data memory not ready).
REQ-004 SHALL have outputs PC_Write 1, IFID_Write 1, IFID_Flush 1, IDEX_Flush 1, Pipe_Freeze 1 (hold EX/MEM and MEM/WB), Stall_Count 32, Flush_Count 32.

Function
REQ-005 SHALL define BranchJr = ID_JumpBranch in {BEQ=1, BNE=2, JR=3}; address 0 never creates a hazard.
REQ-006 SHALL define IDdep(X) = X_RegWrite & X_wrAddr!=0 & ((ID_UseRs & X_wrAddr==ID_rsAddr) | (ID_UseRt & X_wrAddr==ID_rtAddr)).
REQ-007 SHALL compute need, 0..2 stall cycles: BranchJr & IDdep(EX) & EX_MemtoReg -> 2; BranchJr & IDdep(EX) & ~EX_MemtoReg -> 1; BranchJr & IDdep(MEM) & MEM_MemtoReg -> 1.
REQ-008 SHALL compute load-use need 1 when ~BranchJr & EX_MemtoReg & EX_RegWrite & EX_wrAddr!=0 and EX_wrAddr matches ID_rsAddr (ID_UseRs) or ID_rtAddr (ID_UseRt & ~ID_MemWrite); sw rt is served by WB->MEM forwarding.
REQ-009 SHALL use a 2-state FSM RUN/HOLD and a 2-bit remaining counter rem.
REQ-010 In RUN with need>0 and ~Mem_Busy: stall this cycle; rem<=need-1; go HOLD if need-1>0, else stay RUN.
REQ-011 In HOLD with ~Mem_Busy: stall this cycle, rem<=rem-1; go RUN when rem reaches 0; need SHALL NOT be re-evaluated in HOLD.
REQ-012 Stall cycle SHALL drive PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0.
REQ-013 Non-stall cycle with ID_Taken & ~Mem_Busy SHALL drive IFID_Flush=1, PC_Write=1, IFID_Write=1 (no delay slot).
REQ-014 Mem_Busy=1 SHALL override: Pipe_Freeze=1, PC_Write=0, IFID_Write=0, both flushes 0; FSM, rem and counters hold.
REQ-015 Idle cycle (no busy/stall/flush) SHALL drive PC_Write=1, IFID_Write=1, flushes 0, Pipe_Freeze=0.
REQ-016 Priority SHALL be Mem_Busy > stall > flush; ID_Taken during a stall cycle SHALL be ignored (re-evaluated once ID advances).
REQ-017 Stall_Count SHALL increment once per stall cycle; Flush_Count once per IFID_Flush cycle; both saturate at 0xFFFFFFFF.
REQ-018 Control outputs SHALL be combinational from inputs and state (zero latency); counters registered (visible next cycle).

Reset
REQ-019 On rst at clk edge: FSM=RUN, rem=0, Stall_Count=0, Flush_Count=0.
REQ-020 While rst=1: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, Pipe_Freeze=0; rst mid-HOLD SHALL abort stall.

Structure
REQ-021 JumpBranch codes (OTHERS=0, BEQ=1, BNE=2, JR=3, J=4, JAL=7) and FSM state encoding SHALL live in the shared CPU package.
REQ-022 Saturating counters SHALL use one sub-module sat_counter32 (inputs clk, rst, inc; output q), instantiated twice.

Verification
REQ-023 EX lw $8, ID beq $8,$9 -> stall 2 cycles (PC_Write=0, IDEX_Flush=1), then PC_Write=1; Stall_Count=2.
REQ-024 EX add $8, ID jr $8 -> stall exactly 1 cycle; MEM add $8 with ID beq $8 -> no stall (MEM->ID forwarding).
REQ-025 EX lw $8, ID sw $8,0($9) (rt only) -> no stall; ID add $10,$8,$1 -> 1 stall; EX wrAddr=0 -> no stall.
REQ-026 HOLD with rem=1, Mem_Busy=1 for 3 cycles -> Pipe_Freeze=1, rem unchanged; after release 1 stall cycle, Stall_Count +1 only.
REQ-027 ID_Taken=1 idle -> IFID_Flush=1, Flush_Count+1; rst asserted mid-HOLD -> next cycle RUN, counters 0; counter preset near max saturates at 0xFFFFFFFF.
